// File: rtl/key_debounce.sv
// Multi-key debouncer: a two-flop synchroniser per active-low pad feeds a per-key
// four-state FSM that accepts a new level only after STABLE_CNT equal strobe samples.
module key_debounce #(
   parameter int N_KEYS     = 4,
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_down,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   // cnt == CNT_LAST is the "cnt + 1 reaches STABLE_CNT" condition without overflow.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [N_KEYS-1:0] meta_n_q;
   logic [N_KEYS-1:0] sync_n_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_n_q <= '1;
         sync_n_q <= '1;
      end else begin
         meta_n_q <= key_in;
         sync_n_q <= meta_n_q;
      end
   end

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      state_e           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             down_q;
      logic             press_q;
      logic             release_q;

      // Pulses default low every clk, so they stay one cycle wide even if sample_en is held.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            down_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (sample_en) begin
               case (state_q)
                  RELEASED: begin
                     if (!sync_n_q[k]) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                     end else begin
                        cnt_q   <= '0;
                     end
                  end
                  PRESS_WAIT: begin
                     if (sync_n_q[k]) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                     end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        down_q  <= 1'b1;
                        press_q <= 1'b1;
                     end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                     end
                  end
                  PRESSED: begin
                     if (sync_n_q[k]) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                     end
                  end
                  RELEASE_WAIT: begin
                     if (!sync_n_q[k]) begin
                        state_q   <= PRESSED;
                        cnt_q     <= '0;
                     end else if (cnt_q == CNT_LAST) begin
                        state_q   <= RELEASED;
                        cnt_q     <= '0;
                        down_q    <= 1'b0;
                        release_q <= 1'b1;
                     end else begin
                        cnt_q     <= cnt_q + CNT_ONE;
                     end
                  end
                  default: begin
                     state_q <= RELEASED;
                     cnt_q   <= '0;
                  end
               endcase
            end
         end
      end

      assign key_down[k]    = down_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = release_q;
   end

endmodule
